cfir_dec2: RTL and testbench

CIC compensation FIR with decimate-by-2, placed directly downstream of the 32× CIC decimator in the receive chain. It consumes the CIC's 21-bit signed samples and their one-cycle valid strobe. It applies a 15-tap symmetric FIR that flattens the CIC passband droop and emits every second filtered sample. A single time-multiplexed multiplier with a pre-adder is used, since input samples arrive at most once per 32 clocks.

---
 rtl/ddc_fir_pkg.sv | 67 ++++++
 rtl/cfir_dec2_if.sv | 14 +
 rtl/fir_sample_ram.sv | 33 +++
 rtl/cfir_dec2.sv | 160 ++++++++++++++++
 tb/tb_cfir_dec2.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddc_fir_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the CIC
// compensation decimate-by-2 FIR.
package ddc_fir_pkg;

  localparam int DATA_W = 21;
  localparam int COEF_W = 18;
  localparam int TAPS   = 15;
  localparam int HALF   = (TAPS + 1) / 2;
  localparam int SHIFT  = 17;
  localparam int ACC_W  = 44;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    ROUND = 2'd3
  } state_t;

  // Half-way rounding constant and saturation limits, all at accumulator width.
  localparam logic signed [ACC_W-1:0] RND_HALF =
    $signed({{(ACC_W-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}});
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Half of the symmetric impulse response; index 7 is the centre tap.
  // 2*sum(C[0..6]) + C[7] = 2^17, so the DC gain is exactly one.
  function automatic coef_t coef_at(input logic [2:0] k);
    coef_t c;
    case (k)
      3'd0:    c = -18'sd150;
      3'd1:    c = 18'sd420;
      3'd2:    c = -18'sd980;
      3'd3:    c = 18'sd2050;
      3'd4:    c = -18'sd4200;
      3'd5:    c = 18'sd9800;
      3'd6:    c = 18'sd38000;
      3'd7:    c = 18'sd41192;
      default: c = 18'sd0;
    endcase
    return c;
  endfunction

  // Round half up, arithmetic shift down, then clamp to the output range.
  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] shr;
    logic signed [ACC_W-1:0] lim;
    sum = acc + RND_HALF;
    shr = sum >>> SHIFT;
    if (shr > SAT_MAX) begin
      lim = SAT_MAX;
    end else if (shr < SAT_MIN) begin
      lim = SAT_MIN;
    end else begin
      lim = shr;
    end
    return lim[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cfir_dec2_if.sv
// Sample stream in, filtered stream and status out.
interface cfir_dec2_if;
  import ddc_fir_pkg::*;

  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (output in_data, in_valid, input out_data, out_valid, busy, overrun);
  modport slave  (input in_data, in_valid, output out_data, out_valid, busy, overrun);
endinterface

// File: rtl/fir_sample_ram.sv
// 16-deep circular sample buffer: one write port, two combinational reads
// feeding the symmetric pre-adder.
module fir_sample_ram
  import ddc_fir_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr_a,
  input  logic [AW-1:0]            raddr_b,
  output logic signed [DATA_W-1:0] rdata_a,
  output logic signed [DATA_W-1:0] rdata_b
);

  logic signed [DATA_W-1:0] mem_r [DEPTH];

  // Sample write; whole buffer cleared on reset so history starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_r[raddr_a];
  assign rdata_b = mem_r[raddr_b];

endmodule

// File: rtl/cfir_dec2.sv
// 15-tap symmetric CIC compensation FIR, decimate by 2, one shared
// pre-add / multiply / accumulate datapath sequenced by a small FSM.
module cfir_dec2
  import ddc_fir_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cfir_dec2_if.slave bus
);

  state_t                   state_r, state_s;
  logic [2:0]               cnt_r;
  logic [AW-1:0]            wp_r, base_r;
  logic                     ph_r, start_r;
  logic                     trig_s, start_s;
  logic                     mac_s, round_s;
  logic [AW-1:0]            raddr_a_s, raddr_b_s;
  logic signed [DATA_W-1:0] rd_a_s, rd_b_s;
  logic signed [PRE_W-1:0]  pre_s, pre_r;
  coef_t                    coef_r;
  logic signed [PROD_W-1:0] prod_r;
  logic signed [ACC_W-1:0]  acc_r;
  logic                     v1_r, v2_r;
  logic signed [DATA_W-1:0] out_data_r;
  logic                     out_valid_r, busy_r, overrun_r;

  // Every second sample is a trigger; it only starts work when fully idle
  // (start_r covers the cycle between the trigger and entering MAC).
  assign trig_s  = bus.in_valid & ph_r;
  assign start_s = trig_s & (state_r == IDLE) & ~start_r;

  // Operand pair for tap k: x[n-k] and x[n-14+k] (== base+2+k mod 16).
  assign raddr_a_s = base_r - {1'b0, cnt_r};
  assign raddr_b_s = base_r + AW'(2) + {1'b0, cnt_r};

  fir_sample_ram u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (bus.in_valid),
    .waddr   (wp_r),
    .wdata   (bus.in_data),
    .raddr_a (raddr_a_s),
    .raddr_b (raddr_b_s),
    .rdata_a (rd_a_s),
    .rdata_b (rd_b_s)
  );

  // Write pointer, decimation phase, operand base latch and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r      <= {AW{1'b0}};
      ph_r      <= 1'b0;
      base_r    <= {AW{1'b0}};
      start_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      start_r <= start_s;
      if (bus.in_valid) begin
        wp_r <= wp_r + AW'(1);
        ph_r <= ~ph_r;
      end
      if (start_s) begin
        base_r <= wp_r;
      end
      if (trig_s && !start_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  // State register with per-state cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_s != state_r) ? 3'd0 : cnt_r + 3'd1;
    end
  end

  // Next-state: 8 MAC cycles, 2 pipeline drain cycles, 1 rounding cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start_r ? MAC : IDLE;
      MAC:     state_s = (cnt_r == 3'd7) ? DRAIN : MAC;
      DRAIN:   state_s = (cnt_r == 3'd1) ? ROUND : DRAIN;
      ROUND:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State decode for the datapath and output stage.
  always_comb begin
    mac_s   = 1'b0;
    round_s = 1'b0;
    case (state_r)
      MAC:     mac_s   = 1'b1;
      ROUND:   round_s = 1'b1;
      default: begin
        mac_s   = 1'b0;
        round_s = 1'b0;
      end
    endcase
  end

  // Symmetric pre-adder; the centre tap has no partner.
  always_comb begin
    if (cnt_r == 3'd7) begin
      pre_s = PRE_W'(rd_a_s);
    end else begin
      pre_s = PRE_W'(rd_a_s) + PRE_W'(rd_b_s);
    end
  end

  // Pre-add register, multiplier register, accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r  <= {PRE_W{1'b0}};
      coef_r <= {COEF_W{1'b0}};
      v1_r   <= 1'b0;
      prod_r <= {PROD_W{1'b0}};
      v2_r   <= 1'b0;
      acc_r  <= {ACC_W{1'b0}};
    end else begin
      pre_r  <= pre_s;
      coef_r <= coef_at(cnt_r);
      v1_r   <= mac_s;
      prod_r <= PROD_W'(pre_r) * PROD_W'(coef_r);
      v2_r   <= v1_r;
      if (start_s) begin
        acc_r <= {ACC_W{1'b0}};
      end else if (v2_r) begin
        acc_r <= acc_r + ACC_W'(prod_r);
      end
    end
  end

  // Registered outputs: result and strobe on ROUND exit, busy tracks the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= round_s;
      busy_r      <= (state_s != IDLE);
      if (round_s) begin
        out_data_r <= round_sat(acc_r);
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_cfir_dec2.sv
// Scoreboard bench for cfir_dec2: expected outputs come from a direct
// 15-tap convolution model with its own tap table.
module tb_cfir_dec2;
  import ddc_fir_pkg::*;

  logic clk = 1'b0;
  logic rst;
  cfir_dec2_if bus();

  cfir_dec2 dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  int tb_h [15] = '{-150, 420, -980, 2050, -4200, 9800, 38000, 41192,
                    38000, 9800, -4200, 2050, -980, 420, -150};

  int hist[$];
  bit m_ph;
  bit have_last;
  int last_te;
  int exp_val[$];
  int exp_cyc[$];
  int obs_val[$];
  int obs_cyc[$];
  int out_cnt;

  function automatic int model_out();
    longint acc;
    longint r;
    acc = 0;
    for (int k = 0; k < 15; k++) begin
      if (hist.size() > k) acc += longint'(tb_h[k]) * longint'(hist[hist.size()-1-k]);
    end
    r = (acc + 64'sd65536) >>> 17;
    if (r > 1048575) r = 1048575;
    else if (r < -1048576) r = -1048576;
    return int'(r);
  endfunction

  task automatic model_clear();
    hist.delete();
    exp_val.delete();
    exp_cyc.delete();
    m_ph = 1'b0;
    have_last = 1'b0;
    last_te = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Drive one sample; te is the edge that samples it. Returns gap-1 edges later.
  task automatic send(input int v, input int gap, output int te);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = v[DATA_W-1:0];
    te = cyc + 1;
    hist.push_back(v);
    if (m_ph) begin
      if (!(have_last && te <= last_te + 12)) begin
        exp_val.push_back(model_out());
        exp_cyc.push_back(te + 12);
        last_te = te;
        have_last = 1'b1;
      end
    end
    m_ph = ~m_ph;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (gap - 2) @(posedge clk);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic monitor();
    int ev;
    int ec;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        out_cnt++;
        obs_val.push_back(int'(bus.out_data));
        obs_cyc.push_back(cyc);
        vectors++;
        if (exp_val.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out: got out_valid with out_data=%0d at cycle %0d, required none", bus.out_data, cyc);
        end else begin
          ev = exp_val.pop_front();
          ec = exp_cyc.pop_front();
          if (bus.out_data !== DATA_W'(ev) || cyc != ec) begin
            miscompares++;
            $display("FAIL scoreboard: got out_data=%0d at cycle %0d, required %0d at cycle %0d", bus.out_data, cyc, ev, ec);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (bus.out_data !== 21'sd0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got data=%0d valid=%b busy=%b ovr=%b, required 0 0 0 0",
               bus.out_data, bus.out_valid, bus.busy, bus.overrun);
    end
  endtask

  task automatic test_latency();
    int te;
    int te2;
    out_cnt = 0;
    send(5000, 32, te);
    send(-3000, 2, te2);
    wait_to(te2 + 1);
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start: got %b, required 1", bus.busy);
    end
    wait_to(te2 + 11);
    vectors++;
    if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_end: got busy=%b valid=%b, required 1 0", bus.busy, bus.out_valid);
    end
    wait_to(te2 + 12);
    vectors++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency12: got busy=%b valid=%b, required 0 1", bus.busy, bus.out_valid);
    end
    send(7000, 32, te);
    send(123, 32, te);
    repeat (20) @(posedge clk);
    vectors++;
    if (out_cnt != 2) begin
      miscompares++;
      $display("FAIL phase_count: got %0d outputs, required 2", out_cnt);
    end
  endtask

  task automatic test_impulse();
    int te;
    int req [9] = '{-150, -980, -4200, 38000, 38000, -4200, -980, -150, 0};
    do_reset();
    obs_val.delete();
    send(0, 32, te);
    send(131072, 32, te);
    for (int i = 0; i < 16; i++) send(0, 32, te);
    repeat (20) @(posedge clk);
    vectors++;
    if (obs_val.size() != 9) begin
      miscompares++;
      $display("FAIL impulse_count: got %0d, required 9", obs_val.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (obs_val[i] != req[i]) begin
          miscompares++;
          $display("FAIL impulse_tap%0d: got %0d, required %0d", i, obs_val[i], req[i]);
        end
      end
    end
  endtask

  task automatic test_dc();
    int te;
    do_reset();
    obs_val.delete();
    obs_cyc.delete();
    for (int i = 0; i < 24; i++) send(1000, 32, te);
    repeat (20) @(posedge clk);
    vectors++;
    if (obs_val.size() != 12) begin
      miscompares++;
      $display("FAIL dc_count: got %0d, required 12", obs_val.size());
    end else begin
      for (int i = 7; i < 12; i++) begin
        vectors++;
        if (obs_val[i] != 1000) begin
          miscompares++;
          $display("FAIL dc_value%0d: got %0d, required 1000", i, obs_val[i]);
        end
      end
      for (int i = 1; i < 12; i++) begin
        vectors++;
        if (obs_cyc[i] - obs_cyc[i-1] != 64) begin
          miscompares++;
          $display("FAIL dc_spacing%0d: got %0d, required 64", i, obs_cyc[i] - obs_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int te;
    int v;
    int req;
    for (int pol = 0; pol < 2; pol++) begin
      do_reset();
      obs_val.delete();
      send(0, 32, te);
      for (int j = 0; j < 15; j++) begin
        v = (tb_h[14-j] > 0) ? 1048575 : -1048575;
        if (pol == 1) v = -v;
        send(v, 32, te);
      end
      repeat (20) @(posedge clk);
      req = (pol == 0) ? 1048575 : -1048576;
      vectors++;
      if (obs_val.size() != 8 || obs_val[obs_val.size()-1] != req) begin
        miscompares++;
        $display("FAIL saturate_pol%0d: got %0d outputs last=%0d, required 8 last=%0d",
                 pol, obs_val.size(), (obs_val.size() > 0) ? obs_val[obs_val.size()-1] : 0, req);
      end
    end
  endtask

  task automatic test_overrun();
    int te;
    do_reset();
    out_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(int'($urandom_range(0, 2000000)) - 1000000, 4, te);
      if (i == 1 || i == 3) begin
        @(negedge clk);
        vectors++;
        if (bus.overrun !== ((i == 3) ? 1'b1 : 1'b0)) begin
          miscompares++;
          $display("FAIL overrun_trig%0d: got %b, required %b", i, bus.overrun, (i == 3));
        end
      end
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.overrun !== 1'b1 || out_cnt != 2) begin
      miscompares++;
      $display("FAIL overrun_sticky: got ovr=%b outputs=%0d, required 1 and 2", bus.overrun, out_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int te;
    int cnt0;
    send(4321, 32, te);
    send(-777, 2, te);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    cnt0 = out_cnt;
    @(negedge clk);
    vectors++;
    if (bus.out_data !== 21'sd0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got data=%0d busy=%b ovr=%b valid=%b, required all 0",
               bus.out_data, bus.busy, bus.overrun, bus.out_valid);
    end
    repeat (20) @(posedge clk);
    vectors++;
    if (out_cnt != cnt0) begin
      miscompares++;
      $display("FAIL reset_abort: got %0d outputs, required %0d", out_cnt - cnt0, 0);
    end
    send(2500, 32, te);
    send(-1800, 32, te);
    repeat (20) @(posedge clk);
    vectors++;
    if (out_cnt != cnt0 + 1) begin
      miscompares++;
      $display("FAIL reset_retrigger: got %0d outputs, required 1", out_cnt - cnt0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    out_cnt = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_latency();
    test_impulse();
    test_dc();
    test_saturation();
    test_overrun();
    test_reset_mid();
    repeat (5) @(posedge clk);
    vectors++;
    if (exp_val.size() != 0) begin
      miscompares++;
      $display("FAIL missing_out: got %0d pending expected outputs, required 0", exp_val.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
